// File: rtl/pulse_pacer_pkg.sv
// Shared types and helpers for the pulse pacer that feeds the toggle/XOR
// pulse synchronizer.
package pulse_pacer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SPACE = 1'b1
    } pp_state_e;

    // Smallest GAP (in source cycles) that spans three destination cycles,
    // given both clock frequencies in the same unit; never below 2.
    function automatic int unsigned min_gap(input int unsigned src_freq,
                                            input int unsigned dst_freq);
        int unsigned g;
        g = (3 * src_freq + dst_freq - 1) / dst_freq;
        if (g < 2) begin
            g = 2;
        end
        return g;
    endfunction

endpackage

// File: rtl/pulse_pacer.sv
// Queues back-to-back event requests as a count and re-issues them as single
// cycle pulses at least GAP cycles apart, with a sticky drop flag.
module pulse_pacer
    import pulse_pacer_pkg::*;
#(
    parameter int unsigned GAP   = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_in,
    input  logic             clr_ovf,
    output logic             pulse_out,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             overflow,
    output pp_state_e        state_dbg
);

    localparam int unsigned      GW       = (GAP > 2) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0]    GAP_LOAD = GW'(GAP - 1);
    localparam logic [GW-1:0]    GAP_LAST = GW'(1);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    if (GAP < 2) begin : g_bad_gap
        $error("pulse_pacer: GAP must be at least 2");
    end

    pp_state_e        state_q, state_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pulse_q, pulse_d;
    logic             ovf_q, ovf_d;
    logic             fire, drop, inc, dec;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            gap_q   <= '0;
            pend_q  <= '0;
            pulse_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
            pulse_q <= pulse_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;

        fire = (state_q == IDLE) && ((pend_q != '0) || req_in);
        drop = req_in && (pend_q == PEND_MAX) && !fire;
        dec  = fire && (pend_q != '0);
        // A request that fires straight from an empty queue is never counted.
        inc  = req_in && !(fire && (pend_q == '0)) && !drop;

        pulse_d = fire;

        case (state_q)
            IDLE: begin
                if (fire) begin
                    state_d = SPACE;
                    gap_d   = GAP_LOAD;
                end
            end
            SPACE: begin
                gap_d = gap_q - 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gap_d   = '0;
            end
        endcase

        if (inc && !dec) begin
            pend_d = pend_q + 1'b1;
        end else if (dec && !inc) begin
            pend_d = pend_q - 1'b1;
        end

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    assign pulse_out = pulse_q;
    assign pending   = pend_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q != IDLE) || (pend_q != '0);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pulse_pacer.sv
// Directed bench for pulse_pacer: one instance with a 4-bit backlog counter,
// one with a 2-bit counter for the overflow and clear-race cases.
module tb_pulse_pacer;
  import pulse_pacer_pkg::*;

  logic clk;
  logic rstn;
  logic req0, clr0, req1, clr1;
  logic pulse0, busy0, ovf0;
  logic pulse1, busy1, ovf1;
  logic [3:0] pend0;
  logic [1:0] pend1;
  pp_state_e st0, st1;

  int pass_cnt;
  int total_cnt;

  typedef struct {
    logic       req;
    logic       clr;
    logic       pulse;
    logic [3:0] pend;
    logic       busy;
    logic       ovf;
  } vec_t;

  vec_t vec_q[$];

  pulse_pacer #(.GAP(4), .CNT_W(4)) dut0 (
    .clk(clk), .rstn(rstn), .req_in(req0), .clr_ovf(clr0),
    .pulse_out(pulse0), .pending(pend0), .busy(busy0), .overflow(ovf0),
    .state_dbg(st0)
  );

  pulse_pacer #(.GAP(4), .CNT_W(2)) dut1 (
    .clk(clk), .rstn(rstn), .req_in(req1), .clr_ovf(clr1),
    .pulse_out(pulse1), .pending(pend1), .busy(busy1), .overflow(ovf1),
    .state_dbg(st1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void add(input logic req, input logic clr, input logic pulse,
                              input logic [3:0] pend, input logic busy, input logic ovf);
    vec_t v;
    v.req = req; v.clr = clr; v.pulse = pulse; v.pend = pend; v.busy = busy; v.ovf = ovf;
    vec_q.push_back(v);
  endfunction

  task automatic check_inst(input int inst, input string tag, input vec_t v);
    if (inst == 0) begin
      check({tag, ".pulse"}, {3'b0, pulse0}, {3'b0, v.pulse});
      check({tag, ".pending"}, pend0, v.pend);
      check({tag, ".busy"}, {3'b0, busy0}, {3'b0, v.busy});
      check({tag, ".overflow"}, {3'b0, ovf0}, {3'b0, v.ovf});
    end else begin
      check({tag, ".pulse"}, {3'b0, pulse1}, {3'b0, v.pulse});
      check({tag, ".pending"}, {2'b0, pend1}, v.pend);
      check({tag, ".busy"}, {3'b0, busy1}, {3'b0, v.busy});
      check({tag, ".overflow"}, {3'b0, ovf1}, {3'b0, v.ovf});
    end
  endtask

  // driver: one vector per cycle; outputs of cycle k checked, then inputs of cycle k driven
  task automatic run_vecs(input int inst, input string name);
    for (int k = 0; k < vec_q.size(); k++) begin
      @(negedge clk);
      check_inst(inst, $sformatf("%s.c%0d", name, k), vec_q[k]);
      if (inst == 0) begin
        req0 = vec_q[k].req; clr0 = vec_q[k].clr;
      end else begin
        req1 = vec_q[k].req; clr1 = vec_q[k].clr;
      end
    end
    vec_q.delete();
  endtask

  task automatic build_ovf_table(input logic ovf_before, input bit race);
    int pend_tab[21];
    logic ovf_e;
    pend_tab = '{0, 0, 1, 2, 3, 3, 3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0};
    for (int c = 0; c < 21; c++) begin
      if (race) ovf_e = (c <= 6) ? ovf_before : 1'b0;
      else      ovf_e = (c <= 5) ? ovf_before : 1'b1;
      add(c <= 5,
          race && (c == 5 || c == 6),
          (c == 1 || c == 5 || c == 9 || c == 13 || c == 17),
          4'(pend_tab[c]),
          (c >= 1 && c <= 19),
          ovf_e);
    end
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rstn = 1'b0;
    req0 = 1'b0; clr0 = 1'b0; req1 = 1'b0; clr1 = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst.pulse0", {3'b0, pulse0}, 4'h0);
    check("rst.pending0", pend0, 4'h0);
    check("rst.busy0", {3'b0, busy0}, 4'h0);
    check("rst.overflow0", {3'b0, ovf0}, 4'h0);
    check("rst.state0", {3'b0, st0}, {3'b0, IDLE});
    check("rst.pending1", {2'b0, pend1}, 4'h0);
    check("rst.overflow1", {3'b0, ovf1}, 4'h0);
    rstn = 1'b1;

    // single event: pulse at 1, busy 1..3
    add(1,0, 0,0,0,0); add(0,0, 1,0,1,0); add(0,0, 0,0,1,0); add(0,0, 0,0,1,0);
    add(0,0, 0,0,0,0); add(0,0, 0,0,0,0);
    run_vecs(0, "single");

    // burst of three: pulses at 1, 5, 9
    add(1,0, 0,0,0,0); add(1,0, 1,0,1,0); add(1,0, 0,1,1,0); add(0,0, 0,2,1,0);
    add(0,0, 0,2,1,0); add(0,0, 1,1,1,0); add(0,0, 0,1,1,0); add(0,0, 0,1,1,0);
    add(0,0, 0,1,1,0); add(0,0, 1,0,1,0); add(0,0, 0,0,1,0); add(0,0, 0,0,1,0);
    add(0,0, 0,0,0,0);
    run_vecs(0, "burst");

    // re-arm exactly on IDLE re-entry: pending never counts
    add(1,0, 0,0,0,0); add(0,0, 1,0,1,0); add(0,0, 0,0,1,0); add(0,0, 0,0,1,0);
    add(1,0, 0,0,0,0); add(0,0, 1,0,1,0); add(0,0, 0,0,1,0); add(0,0, 0,0,1,0);
    add(0,0, 0,0,0,0);
    run_vecs(0, "rearm");

    // overflow with 2-bit counter: event at cycle 5 dropped
    build_ovf_table(1'b0, 1'b0);
    run_vecs(1, "ovf");

    // drop and clear together keep the flag; clear alone next cycle clears it
    build_ovf_table(1'b1, 1'b1);
    run_vecs(1, "race");

    // reset mid-burst with pending=3 during SPACE
    add(1,0, 0,0,0,0); add(1,0, 1,0,1,0); add(1,0, 0,1,1,0); add(1,0, 0,2,1,0);
    add(1,0, 0,3,1,0);
    run_vecs(0, "prerst");
    @(negedge clk);
    req0 = 1'b0;
    check("prerst.c5.pulse", {3'b0, pulse0}, 4'h1);
    check("prerst.c5.pending", pend0, 4'h3);
    check("prerst.c5.state", {3'b0, st0}, {3'b0, SPACE});
    #2 rstn = 1'b0;
    #1;
    check("midrst.pulse", {3'b0, pulse0}, 4'h0);
    check("midrst.pending", pend0, 4'h0);
    check("midrst.busy", {3'b0, busy0}, 4'h0);
    check("midrst.overflow", {3'b0, ovf0}, 4'h0);
    check("midrst.overflow1", {3'b0, ovf1}, 4'h0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("postrst.c%0d.pulse", k), {3'b0, pulse0}, 4'h0);
      check($sformatf("postrst.c%0d.busy", k), {3'b0, busy0}, 4'h0);
    end
    req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    check("cold.pulse", {3'b0, pulse0}, 4'h1);
    check("cold.pending", pend0, 4'h0);
    @(negedge clk);
    check("cold.pulse_off", {3'b0, pulse0}, 4'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
